gcn_aggregation: RTL and testbench

- Consumer end of the transformation product memory: drives `read_row` into the FM×WM memory and takes back `fm_wm_row`.
- Aggregates transformed node features over an undirected COO edge list: each node's result is its own row plus the rows of all its neighbours.
- Sits after the transformation block. Its `start` is tied to transformation `done`.
- Holds the aggregated matrix in an internal accumulator array, exposed through a combinational read port.

---
 rtl/gcn_aggregation_pkg.sv | 27 ++
 rtl/gcn_aggregation_accumulator_bank.sv | 51 +++++
 rtl/gcn_aggregation.sv | 123 ++++++++++++
 tb/tb_gcn_aggregation.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_aggregation_pkg.sv
// gcn_pkg: shared constants and types for the GCN aggregation block.
// Graph/feature sizes, the FM x WM element/row types, the node index type
// and the aggregation FSM state encoding.
package gcn_pkg;

  localparam int unsigned NUM_OF_NODES    = 6;
  localparam int unsigned WEIGHT_COLS     = 3;
  localparam int unsigned DOT_PROD_WIDTH  = 16;
  localparam int unsigned COO_NUM_OF_COLS = 6;
  localparam int unsigned COO_NUM_OF_ROWS = 2;
  localparam int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS);
  localparam int unsigned ROW_W           = $clog2(NUM_OF_NODES);
  localparam int unsigned EDGE_W          = $clog2(COO_NUM_OF_COLS);

  typedef logic [DOT_PROD_WIDTH-1:0] fm_wm_elem_t;
  typedef fm_wm_elem_t               fm_wm_row_t [WEIGHT_COLS];
  typedef logic [ROW_W-1:0]          node_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EDGE_A,
    EDGE_B,
    DONE
  } agg_state_e;

endpackage

// File: rtl/gcn_aggregation_accumulator_bank.sv
// agg_accumulator_bank: NUM_OF_NODES x WEIGHT_COLS accumulator registers.
// Ports: clk, reset (sync, active-low, clears all entries), load_en
// (overwrite row wr_idx with wr_row), add_en (row wr_idx += wr_row, wrapping),
// rd_idx/rd_row (combinational read, 0 for out-of-range index).
module agg_accumulator_bank
  import gcn_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic                      add_en,
  input  logic [ROW_W-1:0]          wr_idx,
  input  logic [DOT_PROD_WIDTH-1:0] wr_row [0:WEIGHT_COLS-1],
  input  logic [ROW_W-1:0]          rd_idx,
  output logic [DOT_PROD_WIDTH-1:0] rd_row [0:WEIGHT_COLS-1]
);

  fm_wm_row_t acc [NUM_OF_NODES];

  // Load has priority; the controller never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < int'(NUM_OF_NODES); n++) begin
        for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
          acc[n][c] <= '0;
        end
      end
    end else if (load_en) begin
      for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
        acc[wr_idx][c] <= wr_row[c];
      end
    end else if (add_en) begin
      for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
        acc[wr_idx][c] <= acc[wr_idx][c] + wr_row[c];
      end
    end
  end

  // Indices past the last node read back as zero.
  always_comb begin
    for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
      rd_row[c] = '0;
    end
    if (32'(rd_idx) < NUM_OF_NODES) begin
      for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
        rd_row[c] = acc[rd_idx][c];
      end
    end
  end

endmodule

// File: rtl/gcn_aggregation.sv
// gcn_aggregation: sums each node's FM x WM row with the rows of all its
// neighbours over an undirected COO edge list.
// Ports: clk, reset (sync, active-low), start (level), coo_in (edge list,
// row 0 = source, row 1 = destination), fm_wm_row/read_row (FM x WM memory
// read), agg_read_row/agg_row (combinational result read), busy, done,
// coo_err (sticky out-of-range endpoint flag, cleared on start).
module gcn_aggregation
  import gcn_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [COO_BW-1:0]         coo_in [0:COO_NUM_OF_ROWS-1][0:COO_NUM_OF_COLS-1],
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_row [0:WEIGHT_COLS-1],
  output logic [ROW_W-1:0]          read_row,
  input  logic [ROW_W-1:0]          agg_read_row,
  output logic [DOT_PROD_WIDTH-1:0] agg_row [0:WEIGHT_COLS-1],
  output logic                      busy,
  output logic                      done,
  output logic                      coo_err
);

  agg_state_e        state;
  node_idx_t         node_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_next;
  logic [COO_BW-1:0] src;
  logic [COO_BW-1:0] dst;
  logic              edge_ok;
  logic              load_en;
  logic              add_en;
  node_idx_t         wr_idx;

  // Current edge endpoints and accumulator write control.
  always_comb begin
    src       = coo_in[0][edge_cnt];
    dst       = coo_in[1][edge_cnt];
    edge_next = EDGE_W'(edge_cnt + 1'b1);
    edge_ok   = (32'(src) < NUM_OF_NODES) && (32'(dst) < NUM_OF_NODES);
    load_en   = 1'b0;
    add_en    = 1'b0;
    wr_idx    = node_cnt;
    case (state)
      INIT: load_en = 1'b1;
      EDGE_A: begin
        add_en = edge_ok;
        wr_idx = ROW_W'(dst);
      end
      EDGE_B: begin
        add_en = edge_ok;
        wr_idx = ROW_W'(src);
      end
      default: ;
    endcase
  end

  // read_row is registered one state ahead so it already addresses the row
  // that the current state consumes from the combinational memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      node_cnt <= '0;
      edge_cnt <= '0;
      read_row <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      coo_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= INIT;
            node_cnt <= '0;
            edge_cnt <= '0;
            read_row <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            coo_err  <= 1'b0;
          end
        end
        INIT: begin
          if (node_cnt == ROW_W'(NUM_OF_NODES - 1)) begin
            state    <= EDGE_A;
            read_row <= ROW_W'(coo_in[0][0]);
          end else begin
            node_cnt <= ROW_W'(node_cnt + 1'b1);
            read_row <= ROW_W'(node_cnt + 1'b1);
          end
        end
        EDGE_A: begin
          if (!edge_ok) coo_err <= 1'b1;
          state    <= EDGE_B;
          read_row <= ROW_W'(dst);
        end
        EDGE_B: begin
          if (edge_cnt == EDGE_W'(COO_NUM_OF_COLS - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            read_row <= '0;
          end else begin
            state    <= EDGE_A;
            edge_cnt <= edge_next;
            read_row <= ROW_W'(coo_in[0][edge_next]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  agg_accumulator_bank u_bank (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .add_en  (add_en),
    .wr_idx  (wr_idx),
    .wr_row  (fm_wm_row),
    .rd_idx  (agg_read_row),
    .rd_row  (agg_row)
  );

endmodule

// File: tb/tb_gcn_aggregation.sv
// tb_gcn_aggregation: self-checking bench for gcn_aggregation with a
// behavioural FM x WM memory, an edge-list aggregation model and a per-cycle
// timeline monitor (busy/done/read_row/coo_err).
module tb_gcn_aggregation;
  import gcn_pkg::*;

  localparam int N = int'(NUM_OF_NODES);
  localparam int W = int'(WEIGHT_COLS);
  localparam int E = int'(COO_NUM_OF_COLS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [COO_BW-1:0]         coo_in [0:COO_NUM_OF_ROWS-1][0:COO_NUM_OF_COLS-1];
  logic [DOT_PROD_WIDTH-1:0] fm_wm_row [0:WEIGHT_COLS-1];
  logic [ROW_W-1:0]          read_row;
  logic [ROW_W-1:0]          agg_read_row = '0;
  logic [DOT_PROD_WIDTH-1:0] agg_row [0:WEIGHT_COLS-1];
  logic busy, done, coo_err;

  logic [15:0] mem [N][W];
  int          src [E];
  int          dst [E];
  logic [15:0] exp_acc [N][W];
  logic        exp_err;

  int errors = 0;
  int checks = 0;
  int k = 0;
  bit tracking = 1'b0;

  gcn_aggregation dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .coo_in       (coo_in),
    .fm_wm_row    (fm_wm_row),
    .read_row     (read_row),
    .agg_read_row (agg_read_row),
    .agg_row      (agg_row),
    .busy         (busy),
    .done         (done),
    .coo_err      (coo_err)
  );

  always #5 clk = ~clk;

  // Memory: rows past the last node return junk that must never be summed.
  always_comb begin
    for (int c = 0; c < W; c++) begin
      fm_wm_row[c] = (int'(read_row) < N) ? mem[read_row][c] : 16'hBEEF;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Expected read_row at sample kk after the start edge.
  function automatic int exp_rr(input int kk);
    int j;
    if (kk <= N) return kk - 1;
    if (kk <= N + 2 * E) begin
      j = kk - N - 1;
      return (j % 2 == 0) ? src[j / 2] : dst[j / 2];
    end
    return 0;
  endfunction

  // Aggregation model: self row plus each in-range edge's rows both ways.
  function automatic void compute_model();
    exp_err = 1'b0;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < W; c++) exp_acc[n][c] = mem[n][c];
    for (int e = 0; e < E; e++) begin
      if (src[e] >= N || dst[e] >= N) exp_err = 1'b1;
      else begin
        for (int c = 0; c < W; c++) begin
          exp_acc[dst[e]][c] = exp_acc[dst[e]][c] + mem[src[e]][c];
          exp_acc[src[e]][c] = exp_acc[src[e]][c] + mem[dst[e]][c];
        end
      end
    end
  endfunction

  task automatic set_graph(input int s0, s1, s2, s3, s4, s5, d0, d1, d2, d3, d4, d5);
    src = '{s0, s1, s2, s3, s4, s5};
    dst = '{d0, d1, d2, d3, d4, d5};
    for (int e = 0; e < E; e++) begin
      coo_in[0][e] = COO_BW'(src[e]);
      coo_in[1][e] = COO_BW'(dst[e]);
    end
  endtask

  task automatic set_default_rows();
    for (int n = 0; n < N; n++) begin
      mem[n][0] = 16'(n + 1);
      mem[n][1] = 16'(10 * (n + 1));
      mem[n][2] = 16'(100 * (n + 1));
    end
  endtask

  task automatic sweep(input string tag, input bit zero);
    for (int n = 0; n < 8; n++) begin
      agg_read_row = ROW_W'(n);
      #1;
      for (int c = 0; c < W; c++)
        chk($sformatf("%s agg_row[%0d][%0d]", tag, n, c), 32'(agg_row[c]),
            (zero || n >= N) ? 32'd0 : 32'(exp_acc[n][c]));
    end
  endtask

  // Timeline monitor: sample 1 follows the start edge; busy for 2E+N samples.
  always @(negedge clk) begin
    if (tracking) begin
      k = k + 1;
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'(k <= N + 2 * E));
      chk($sformatf("done k=%0d", k), 32'(done), 32'(k == N + 2 * E + 1));
      chk($sformatf("read_row k=%0d", k), 32'(read_row), 32'(exp_rr(k)));
      if (k == 1) chk("coo_err cleared", 32'(coo_err), 32'd0);
      if (k == N + 2 * E + 1) begin
        chk("coo_err", 32'(coo_err), 32'(exp_err));
        if (start) k = 0;
        else tracking = 1'b0;
      end
    end
  end

  task automatic begin_pass();
    compute_model();
    @(negedge clk); #1;
    k = 0;
    tracking = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_pass(input string tag);
    begin_pass();
    repeat (N + 2 * E) @(negedge clk);
    #1;
    sweep(tag, 1'b0);
  endtask

  initial begin
    set_default_rows();
    set_graph(0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset read_row", 32'(read_row), 32'd0);
    chk("reset coo_err", 32'(coo_err), 32'd0);
    sweep("reset", 1'b1);
    reset = 1'b1;

    // Ring graph with literal pins.
    run_pass("ring");
    chk("pin ring acc0", {exp_acc[0][0], exp_acc[0][2]}, {16'd9, 16'd900});
    chk("pin ring acc3", {exp_acc[3][1], exp_acc[3][2]}, {16'd120, 16'd1200});
    agg_read_row = 3'd0; #1;
    chk("lit ring agg0", {agg_row[0], agg_row[1]}, {16'd9, 16'd90});

    // Reset in the middle of the edge phase.
    begin_pass();
    repeat (8) @(negedge clk);
    #1;
    tracking = 1'b0;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset read_row", 32'(read_row), 32'd0);
    sweep("midreset", 1'b1);
    reset = 1'b1;
    run_pass("after reset");

    // Self-loop and duplicate edges.
    set_graph(2, 2, 0, 0, 0, 0, 2, 4, 0, 0, 0, 0);
    run_pass("selfloop");
    chk("pin self acc2", {exp_acc[2][0], exp_acc[2][2]}, {16'd14, 16'd1400});
    chk("pin self acc0", {exp_acc[0][0], exp_acc[0][1]}, {16'd9, 16'd90});

    // Out-of-range endpoint.
    set_graph(0, 7, 2, 3, 4, 5, 1, 2, 3, 4, 5, 0);
    run_pass("oor");
    chk("pin oor err", 32'(exp_err), 32'd1);
    chk("lit oor coo_err", 32'(coo_err), 32'd1);

    // Wrap-around arithmetic; also sees coo_err cleared at the start.
    set_graph(0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 0);
    for (int n = 0; n < N; n++)
      for (int c = 0; c < W; c++) mem[n][c] = 16'hFFFF;
    run_pass("overflow");
    chk("pin overflow", {exp_acc[0][0], exp_acc[5][2]}, {16'hFFFD, 16'hFFFD});

    // start held high: back-to-back passes.
    set_default_rows();
    compute_model();
    @(negedge clk); #1;
    k = 0;
    tracking = 1'b1;
    start = 1'b1;
    repeat (N + 2 * E + 1 + 6) @(negedge clk);
    #1;
    start = 1'b0;
    repeat (2 * E + 1) @(negedge clk);
    #1;
    sweep("held", 1'b0);

    // start pulsed while busy is ignored.
    set_graph(5, 3, 1, 0, 2, 4, 0, 3, 4, 1, 5, 2);
    compute_model();
    @(negedge clk); #1;
    k = 0;
    tracking = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (N + 2 * E + 1 - 6) @(negedge clk);
    #1;
    sweep("pulse", 1'b0);

    // Randomized passes.
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < N; n++)
        for (int c = 0; c < W; c++) mem[n][c] = 16'($urandom_range(0, 65535));
      set_graph($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 7),
                $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      run_pass($sformatf("rand%0d", r));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
